// File: rtl/mem_port_arbiter_if.sv
// Bundle for the shared memory port: fetch requester, data requester and memory bus.
// master is the arbiter's view; slave is the pipeline/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Handshake: a requester raises *_req with stable address/data and holds it
    // until the one-cycle *_ack pulse; the arbiter holds mem_req/mem_* stable
    // until the memory answers with mem_ready, which is only sampled while mem_req=1.
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              if_stall;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;
    logic              d_stall;

    logic              bus_err;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_rdata, if_ack, if_stall, d_rdata, d_ack, d_stall, bus_err,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_ack, if_stall, d_rdata, d_ack, d_stall, bus_err,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single-ported memory: data has priority, a starvation
// counter forces fetch through, and a watchdog aborts transfers the memory never finishes.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.master  bus,
    output logic [1:0]          dbg_state,
    output logic [3:0]          dbg_starve_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        XFER_D = 2'd1,
        XFER_I = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] starve_cnt;
    logic [9:0] timer;

    logic if_elig;
    logic d_elig;
    logic starve_hit;
    logic grant_i;
    logic grant_d;
    logic timeout_hit;

    // A requester being acked this cycle still has req high; masking it stops a re-grant.
    assign if_elig     = bus.if_req & ~bus.if_ack;
    assign d_elig      = bus.d_req & ~bus.d_ack;
    assign starve_hit  = (starve_cnt == 4'(STARVE_LIMIT));
    assign grant_i     = if_elig & (starve_hit | ~d_elig);
    assign grant_d     = d_elig & ~grant_i;
    assign timeout_hit = (timer == 10'(TIMEOUT - 1));

    assign bus.if_stall = bus.if_req & ~bus.if_ack;
    assign bus.d_stall  = bus.d_req & ~bus.d_ack;

    assign dbg_state      = state;
    assign dbg_starve_cnt = starve_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            starve_cnt    <= 4'd0;
            timer         <= 10'd0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= {ADDR_W{1'b0}};
            bus.mem_wdata <= {DATA_W{1'b0}};
            bus.if_ack    <= 1'b0;
            bus.d_ack     <= 1'b0;
            bus.bus_err   <= 1'b0;
            bus.if_rdata  <= {DATA_W{1'b0}};
            bus.d_rdata   <= {DATA_W{1'b0}};
        end else begin
            bus.if_ack  <= 1'b0;
            bus.d_ack   <= 1'b0;
            bus.bus_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_i) begin
                        state         <= XFER_I;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= bus.if_addr;
                        bus.mem_wdata <= {DATA_W{1'b0}};
                        timer         <= 10'd0;
                        starve_cnt    <= 4'd0;
                    end else if (grant_d) begin
                        state         <= XFER_D;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= bus.d_we;
                        bus.mem_addr  <= bus.d_addr;
                        bus.mem_wdata <= bus.d_wdata;
                        timer         <= 10'd0;
                        if (bus.if_req && starve_cnt != 4'hF) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end
                end

                XFER_D, XFER_I: begin
                    // mem_ready wins over a timeout landing in the same cycle.
                    if (bus.mem_ready) begin
                        state       <= IDLE;
                        bus.mem_req <= 1'b0;
                        if (state == XFER_D) begin
                            bus.d_ack   <= 1'b1;
                            bus.d_rdata <= bus.mem_rdata;
                        end else begin
                            bus.if_ack   <= 1'b1;
                            bus.if_rdata <= bus.mem_rdata;
                        end
                    end else if (timeout_hit) begin
                        state       <= IDLE;
                        bus.mem_req <= 1'b0;
                        bus.bus_err <= 1'b1;
                        if (state == XFER_D) begin
                            bus.d_ack   <= 1'b1;
                            bus.d_rdata <= {DATA_W{1'b0}};
                        end else begin
                            bus.if_ack   <= 1'b1;
                            bus.if_rdata <= {DATA_W{1'b0}};
                        end
                    end else begin
                        timer <= timer + 10'd1;
                    end
                end

                default: begin
                    state       <= IDLE;
                    bus.mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle-level checks in one initial block plus an
// ack monitor that pops expected responses from a scoreboard queue.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int W      = DATA_W + 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XD   = 2'd1;
    localparam logic [1:0] ST_XI   = 2'd2;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;
    logic [3:0] dbg_starve_cnt;

    int total = 0;
    int bad   = 0;

    // Entry layout: {is_data, bus_err, rdata}
    logic [W-1:0] exp_q[$];

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .STARVE_LIMIT(4),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .dbg_state(dbg_state),
        .dbg_starve_cnt(dbg_starve_cnt)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver / check helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic is_d, input logic err, input logic [DATA_W-1:0] data);
        exp_q.push_back({is_d, err, data});
    endtask

    task automatic mem_answer(input logic [DATA_W-1:0] data);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = data;
    endtask

    // Scoreboard monitor: every ack must match the oldest expected response
    always @(negedge clk) begin
        if (bus.if_ack || bus.d_ack) begin : mon
            logic [W-1:0] obs;
            check("ack_exclusive", {63'd0, bus.if_ack & bus.d_ack}, 64'd0);
            obs = {bus.d_ack, bus.bus_err, bus.d_ack ? bus.d_rdata : bus.if_rdata};
            check("sb_has_entry", {63'd0, exp_q.size() != 0}, 64'd1);
            if (exp_q.size() != 0) begin
                check("sb_resp", 64'(obs), 64'(exp_q.pop_front()));
            end
        end
    end

    // Directed stimulus
    initial begin
        reset         = 1'b1;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;

        tick();
        tick();
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        check("rst_mem_req", 64'(bus.mem_req), 64'd0);
        check("rst_mem_we", 64'(bus.mem_we), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check("rst_acks", 64'({bus.if_ack, bus.d_ack, bus.bus_err}), 64'd0);
        check("rst_rdata", 64'({bus.if_rdata, bus.d_rdata}), 64'd0);
        check("rst_starve", 64'(dbg_starve_cnt), 64'd0);
        reset = 1'b0;

        // Stray mem_ready with no transaction must be ignored
        mem_answer(32'hFFFF_FFFF);
        tick();
        tick();
        check("stray_ready_idle", 64'(dbg_state), 64'(ST_IDLE));
        check("stray_ready_req", 64'(bus.mem_req), 64'd0);
        bus.mem_ready = 1'b0;

        // Single fetch, zero-wait
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        #1;
        check("t1_stall_c0", 64'(bus.if_stall), 64'd1);
        tick();
        check("t1_mem_req", 64'(bus.mem_req), 64'd1);
        check("t1_mem_addr", 64'(bus.mem_addr), 64'h100);
        check("t1_mem_we", 64'(bus.mem_we), 64'd0);
        check("t1_state", 64'(dbg_state), 64'(ST_XI));
        check("t1_stall_c1", 64'(bus.if_stall), 64'd1);
        mem_answer(32'h0050_0093);
        push_exp(1'b0, 1'b0, 32'h0050_0093);
        tick();
        check("t1_if_ack", 64'(bus.if_ack), 64'd1);
        check("t1_if_rdata", 64'(bus.if_rdata), 64'h0050_0093);
        check("t1_stall_c2", 64'(bus.if_stall), 64'd0);
        check("t1_mem_req_drop", 64'(bus.mem_req), 64'd0);
        bus.if_req    = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        check("t1_ack_pulse", 64'(bus.if_ack), 64'd0);

        // Store with 3 wait states
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h2000;
        bus.d_wdata = 32'hDEAD_BEEF;
        #1;
        check("t2_d_stall", 64'(bus.d_stall), 64'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("t2_hold_req", 64'(bus.mem_req), 64'd1);
            check("t2_hold_we", 64'(bus.mem_we), 64'd1);
            check("t2_hold_addr", 64'(bus.mem_addr), 64'h2000);
            check("t2_hold_wdata", 64'(bus.mem_wdata), 64'hDEAD_BEEF);
            check("t2_no_ack_yet", 64'(bus.d_ack), 64'd0);
            if (i == 3) begin
                mem_answer(32'h1234_5678);
                push_exp(1'b1, 1'b0, 32'h1234_5678);
            end
            tick();
        end
        check("t2_d_ack", 64'(bus.d_ack), 64'd1);
        check("t2_bus_err", 64'(bus.bus_err), 64'd0);
        check("t2_d_stall_ack", 64'(bus.d_stall), 64'd0);
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        check("t2_ack_pulse", 64'(bus.d_ack), 64'd0);

        // Simultaneous requests: data first, fetch granted in the data ack cycle
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h104;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h3000;
        tick();
        check("t3_data_first", 64'(dbg_state), 64'(ST_XD));
        check("t3_addr_d", 64'(bus.mem_addr), 64'h3000);
        check("t3_starve_1", 64'(dbg_starve_cnt), 64'd1);
        mem_answer(32'hA5A5_0001);
        push_exp(1'b1, 1'b0, 32'hA5A5_0001);
        tick();
        check("t3_d_ack_c2", 64'(bus.d_ack), 64'd1);
        check("t3_if_stall_c2", 64'(bus.if_stall), 64'd1);
        bus.d_req     = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        check("t3_fetch_xfer", 64'(dbg_state), 64'(ST_XI));
        check("t3_addr_i", 64'(bus.mem_addr), 64'h104);
        check("t3_starve_0", 64'(dbg_starve_cnt), 64'd0);
        mem_answer(32'h0000_0013);
        push_exp(1'b0, 1'b0, 32'h0000_0013);
        tick();
        check("t3_if_ack_c4", 64'(bus.if_ack), 64'd1);
        bus.if_req    = 1'b0;
        bus.mem_ready = 1'b0;
        tick();

        // Starvation guard: four data grants won against fetch, then fetch is forced through
        for (int r = 1; r <= 4; r++) begin
            bus.if_req  = 1'b1;
            bus.if_addr = 32'h200;
            bus.d_req   = 1'b1;
            bus.d_we    = 1'b1;
            bus.d_addr  = 32'h4000 + 32'(r * 4);
            bus.d_wdata = 32'(r);
            tick();
            check("t4_data_wins", 64'(dbg_state), 64'(ST_XD));
            check("t4_starve_cnt", 64'(dbg_starve_cnt), 64'(r));
            bus.if_req = 1'b0;
            mem_answer(32'(r));
            push_exp(1'b1, 1'b0, 32'(r));
            tick();
            check("t4_d_ack", 64'(bus.d_ack), 64'd1);
            bus.d_req     = 1'b0;
            bus.mem_ready = 1'b0;
            tick();
        end
        bus.if_req  = 1'b1;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h4100;
        bus.d_wdata = 32'h55;
        tick();
        check("t4_fetch_forced", 64'(dbg_state), 64'(ST_XI));
        check("t4_forced_addr", 64'(bus.mem_addr), 64'h200);
        check("t4_forced_we", 64'(bus.mem_we), 64'd0);
        check("t4_starve_clr", 64'(dbg_starve_cnt), 64'd0);
        mem_answer(32'h0000_0777);
        push_exp(1'b0, 1'b0, 32'h0000_0777);
        tick();
        check("t4_if_ack", 64'(bus.if_ack), 64'd1);
        bus.if_req    = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        check("t4_data_resumes", 64'(dbg_state), 64'(ST_XD));
        check("t4_resume_addr", 64'(bus.mem_addr), 64'h4100);
        check("t4_resume_wdata", 64'(bus.mem_wdata), 64'h55);
        check("t4_starve_stays", 64'(dbg_starve_cnt), 64'd0);
        mem_answer(32'h0000_0999);
        push_exp(1'b1, 1'b0, 32'h0000_0999);
        tick();
        check("t4_resume_ack", 64'(bus.d_ack), 64'd1);
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.mem_ready = 1'b0;
        tick();

        // Timeout: fetch never answered
        bus.mem_rdata = 32'hBAD0_BAD0;
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h300;
        tick();
        check("t5_mem_req_rose", 64'(bus.mem_req), 64'd1);
        push_exp(1'b0, 1'b1, 32'h0);
        for (int c = 2; c <= 8; c++) begin
            tick();
            check("t5_waiting_ack", 64'(bus.if_ack), 64'd0);
            check("t5_waiting_req", 64'(bus.mem_req), 64'd1);
        end
        tick();
        check("t5_if_ack", 64'(bus.if_ack), 64'd1);
        check("t5_bus_err", 64'(bus.bus_err), 64'd1);
        check("t5_if_rdata", 64'(bus.if_rdata), 64'd0);
        check("t5_no_d_ack", 64'(bus.d_ack), 64'd0);
        bus.if_req = 1'b0;
        tick();
        check("t5_idle", 64'(dbg_state), 64'(ST_IDLE));
        check("t5_req_low", 64'(bus.mem_req), 64'd0);
        check("t5_err_pulse", 64'(bus.bus_err), 64'd0);

        // Reset in the second XFER_D cycle
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h400;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h5000;
        tick();
        check("t6_xfer_d", 64'(dbg_state), 64'(ST_XD));
        check("t6_starve_1", 64'(dbg_starve_cnt), 64'd1);
        tick();
        check("t6_still_xfer", 64'(dbg_state), 64'(ST_XD));
        reset      = 1'b1;
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        tick();
        check("t6_req_low", 64'(bus.mem_req), 64'd0);
        check("t6_acks_low", 64'({bus.if_ack, bus.d_ack, bus.bus_err}), 64'd0);
        check("t6_starve_clr", 64'(dbg_starve_cnt), 64'd0);
        check("t6_idle", 64'(dbg_state), 64'(ST_IDLE));
        check("t6_d_rdata_clr", 64'(bus.d_rdata), 64'd0);
        reset = 1'b0;
        tick();
        check("t6_no_late_ack", 64'({bus.if_ack, bus.d_ack}), 64'd0);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h404;
        tick();
        check("t6_new_req", 64'(bus.mem_req), 64'd1);
        check("t6_new_addr", 64'(bus.mem_addr), 64'h404);
        mem_answer(32'h00A0_0113);
        push_exp(1'b0, 1'b0, 32'h00A0_0113);
        tick();
        check("t6_new_ack", 64'(bus.if_ack), 64'd1);
        check("t6_new_rdata", 64'(bus.if_rdata), 64'h00A0_0113);
        bus.if_req    = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        tick();

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported instruction/data memory bus between two requesters: the IF stage (read-only fetch) and the MEM stage (load/store, driven by busWe).
- Serialises transactions with a 3-state FSM and holds address, write data and write enable stable until the memory handshakes.
- Returns read data to the owning requester and generates the stall signals the pipeline feeds into the control unit's stall input.
- Data has fixed priority over fetch, with a starvation guard so fetch always makes progress. A watchdog terminates hung transactions.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive data grants made while fetch waits before fetch is forced to win (1..15).
- TIMEOUT, 255, cycles in XFER without mem_ready before abort (1..1023).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched word; valid while if_ack.
- if_ack  out  1  one-cycle completion pulse for fetch.
- if_stall  out  1  if_req & ~if_ack (combinational).
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  data write enable (busWe).
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data; valid while d_ack.
- d_ack  out  1  one-cycle completion pulse for data.
- d_stall  out  1  d_req & ~d_ack (combinational).
- bus_err  out  1  pulses with the ack of a timed-out transaction.
- mem_req  out  1  memory transaction valid.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ready.
- mem_ready  in  1  memory completion; sampled only while mem_req=1.

Behaviour:
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ack=0, d_ack=0, bus_err=0, if_rdata=0, d_rdata=0, starve_cnt=0, timer=0.
- FSM states: IDLE, XFER_D, XFER_I. Every output except the two stalls is registered.
- IDLE:
  - Eligible requester = req high and its ack not high in the current cycle. This mask prevents re-granting a requester in the cycle it is acked.
  - Grant fetch if starve_cnt == STARVE_LIMIT and fetch is eligible.
  - Otherwise grant data if data is eligible, else grant fetch if fetch is eligible, else stay in IDLE.
- On grant:
  - Next cycle: state=XFER_x and mem_req=1. mem_addr, mem_we (0 for fetch) and mem_wdata are latched from the winner; timer=0.
  - starve_cnt: increments (saturating) on a data grant while if_req is pending; clears on a fetch grant; unchanged otherwise.
- XFER_x:
  - mem_* outputs are held constant.
  - On mem_ready=1: next cycle state=IDLE, mem_req=0, owner ack=1, owner rdata=mem_rdata (rdata is captured for writes too; don't-care).
  - Otherwise timer increments. When timer reaches TIMEOUT-1 with no mem_ready: next cycle state=IDLE, mem_req=0, owner ack=1, bus_err=1, owner rdata=0.
- Latency:
  - Request seen in IDLE at cycle N gives mem_req at N+1.
  - Zero-wait memory (mem_ready at N+1) gives ack at N+2.
  - Each memory wait cycle adds 1.
- Back-to-back throughput: one transaction per 2 cycles minimum. The ack cycle is IDLE and may grant the other requester.
- Acks and bus_err are one-cycle pulses. At most one of if_ack/d_ack is high in any cycle.
- Requests are not queued. Dropping a req before ack is illegal; the transaction completes regardless and the ack is still pulsed.
- mem_ready while mem_req=0 is ignored.
- Reset mid-transaction: the next cycle is in reset state; no ack or bus_err is emitted for the aborted transfer.

Test Plan:
- Single fetch, zero-wait: if_req=1, if_addr=0x100 at cycle 0; mem_ready=1 at cycle 1 with mem_rdata=0x00500093. Required: mem_req=1, mem_addr=0x100, mem_we=0 at cycle 1; if_ack=1, if_rdata=0x00500093 at cycle 2; if_stall=1 at cycles 0–1 and 0 at cycle 2.
- Store with 3 wait states: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF. Required: mem_* stable for 4 cycles; d_ack=1 exactly one cycle after the mem_ready cycle; bus_err=0.
- Simultaneous requests: if_req and d_req both high at cycle 0. Required: data granted first (d_ack at cycle 2); fetch granted in cycle 2 (d_ack cycle); if_ack at cycle 4.
- Starvation with STARVE_LIMIT=4: d_req held continuously (re-asserted after each ack) with if_req pending. Required: 4 data grants, then a fetch grant, then starve_cnt=0 and data resumes.
- Timeout with TIMEOUT=8: fetch request, mem_ready never asserted. Required: d_ack=0, if_ack=1 with bus_err=1 exactly 8 cycles after mem_req rose; if_rdata=0; FSM returns to IDLE.
- Reset mid-transfer: reset=1 in the second XFER_D cycle. Required: next cycle mem_req=0, all acks=0, starve_cnt=0; a new fetch afterwards completes normally.
